// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target peripheral.
package spi_target_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  // CPU register index
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_FILL   = 2'd3
  } reg_addr_e;

  // STATUS bit positions
  localparam int unsigned STAT_RX_FULL  = 0;
  localparam int unsigned STAT_TX_FULL  = 1;
  localparam int unsigned STAT_OVERRUN  = 2;
  localparam int unsigned STAT_BUSY     = 3;
  localparam int unsigned STAT_UNDERRUN = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_RX_IRQ_EN = 1;

  // Frame state
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer with a third stage for edge detection.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchronize the async pin and keep one delayed copy for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with a four-register CPU interface.
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [DATA_W-1:0] FILL_DEFAULT = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_rwb,
  input  logic [1:0]        i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_irqb,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe
);

  state_e            state;
  logic [DATA_W-1:0] rx_buf, tx_buf, fill, rx_sh, tx_sh, rx_next;
  logic [DATA_W-1:0] status, ctrl;
  logic [CNT_W-1:0]  bit_cnt;
  logic              en, rx_irq_en;
  logic              rx_full, tx_full, overrun, underrun;
  logic              mosi_s1, mosi_s2;
  logic              sck_level, sck_rise, sck_fall;
  logic              cs_level, cs_rise, cs_fall;
  logic              busy;
  reg_addr_e         addr;
  logic              rd_data, wr_data, wr_status, wr_ctrl, wr_fill;
  logic              frame_start, in_shift, do_rise, do_fall, reload, byte_done;

  sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .d     (i_spi_clk),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // CS idles high, so its synchronizer resets to the deasserted level
  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .d     (i_spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign busy = ~cs_level;
  assign addr = reg_addr_e'(i_addr);

  assign rd_data   = i_cs &  i_rwb & (addr == REG_DATA);
  assign wr_data   = i_cs & ~i_rwb & (addr == REG_DATA);
  assign wr_status = i_cs & ~i_rwb & (addr == REG_STATUS);
  assign wr_ctrl   = i_cs & ~i_rwb & (addr == REG_CTRL);
  assign wr_fill   = i_cs & ~i_rwb & (addr == REG_FILL);

  // CS rising edge ends the frame and takes priority over a coincident SCK edge
  assign frame_start = (state == IDLE) & en & cs_fall;
  assign in_shift    = (state == SHIFT) & en & ~cs_rise;
  assign do_rise     = in_shift & sck_rise & sck_level;
  assign do_fall     = in_shift & sck_fall;
  assign reload      = frame_start | (do_fall & (bit_cnt == CNT_W'(8)));
  assign byte_done   = do_rise & (bit_cnt == CNT_W'(7));
  assign rx_next     = {rx_sh[DATA_W-2:0], mosi_s2};

  assign o_spi_miso    = tx_sh[DATA_W-1];
  assign o_spi_miso_oe = en & busy;
  assign o_irqb        = ~(rx_irq_en & rx_full);

  // Read mux; register reads have no combinational side effects
  always_comb begin
    o_data = '0;
    status = '0;
    ctrl   = '0;
    status[STAT_RX_FULL]  = rx_full;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_OVERRUN]  = overrun;
    status[STAT_BUSY]     = busy;
    status[STAT_UNDERRUN] = underrun;
    ctrl[CTRL_EN]         = en;
    ctrl[CTRL_RX_IRQ_EN]  = rx_irq_en;
    case (addr)
      REG_DATA:   o_data = rx_buf;
      REG_STATUS: o_data = status;
      REG_CTRL:   o_data = ctrl;
      REG_FILL:   o_data = fill;
      default:    o_data = '0;
    endcase
  end

  // Register file, frame FSM and shifters; later assignments win so hardware sets beat W1C
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rx_buf    <= '0;
      tx_buf    <= '0;
      fill      <= FILL_DEFAULT;
      en        <= 1'b0;
      rx_irq_en <= 1'b0;
      rx_full   <= 1'b0;
      tx_full   <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      bit_cnt   <= '0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
    end else begin
      mosi_s1 <= i_spi_mosi;
      mosi_s2 <= mosi_s1;

      if (rd_data) rx_full <= 1'b0;
      if (wr_status) begin
        if (i_data[STAT_OVERRUN])  overrun  <= 1'b0;
        if (i_data[STAT_UNDERRUN]) underrun <= 1'b0;
      end
      if (wr_ctrl) begin
        en        <= i_data[CTRL_EN];
        rx_irq_en <= i_data[CTRL_RX_IRQ_EN];
      end
      if (wr_fill) fill <= i_data;

      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (cs_fall) state <= SHIFT;
          SHIFT:   if (cs_rise) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (reload) begin
        if (tx_full) begin
          tx_sh   <= tx_buf;
          tx_full <= 1'b0;
        end else begin
          tx_sh    <= fill;
          underrun <= 1'b1;
        end
        bit_cnt <= '0;
      end else if (do_fall) begin
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end

      if (do_rise) begin
        rx_sh   <= rx_next;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (byte_done) begin
          if (rx_full && !rd_data) begin
            overrun <= 1'b1;
          end else begin
            rx_buf  <= rx_next;
            rx_full <= 1'b1;
          end
        end
      end

      // A CPU write in the reload cycle is kept for the next byte
      if (wr_data) begin
        tx_buf  <= i_data;
        tx_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: CPU register access plus a bit-banged SPI initiator.
module tb_spi_target;

  localparam int HALF = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_FILL = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       rwb = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       irqb;
  logic       spi_cs_n = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd, rx, rx2;

  always #5 clk = ~clk;

  spi_target #(.FILL_DEFAULT(8'hFF)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cs          (cs),
    .i_rwb         (rwb),
    .i_addr        (addr),
    .i_data        (wdata),
    .o_data        (rdata),
    .o_irqb        (irqb),
    .i_spi_cs_n    (spi_cs_n),
    .i_spi_clk     (spi_clk),
    .i_spi_mosi    (spi_mosi),
    .o_spi_miso    (spi_miso),
    .o_spi_miso_oe (spi_miso_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rwb = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; rwb = 1'b1;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rwb = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic spi_begin();
    spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_end();
    spi_cs_n = 1'b1;
    tick(4);
    spi_clk = 1'b0;
    tick(HALF);
  endtask

  // Shift nbits MSB first; hold_last leaves SCK high after the final rise
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit hold_last,
                          output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      tick(HALF);
      got = {got[6:0], spi_miso};
      spi_clk = 1'b1;
      tick(HALF);
      if (!(hold_last && i == nbits - 1)) spi_clk = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_irqb", 32'(irqb), 32'h1);
    check("rst_oe", 32'(spi_miso_oe), 32'h0);
    check("rst_miso", 32'(spi_miso), 32'h0);
    rst = 1'b0;
    tick(1);
    cpu_rd(A_STAT, rd); check("rst_status", 32'(rd), 32'h00);
    cpu_rd(A_CTRL, rd); check("rst_ctrl", 32'(rd), 32'h00);
    cpu_rd(A_FILL, rd); check("rst_fill", 32'(rd), 32'hFF);
    cpu_rd(A_DATA, rd); check("rst_data", 32'(rd), 32'h00);

    // Single byte
    cpu_wr(A_CTRL, 8'h01);
    cpu_wr(A_DATA, 8'hA5);
    cpu_rd(A_STAT, rd); check("sb_status_txfull", 32'(rd), 32'h02);
    spi_begin();
    spi_xfer(8'h3C, 8, 1'b1, rx);
    cpu_rd(A_STAT, rd); check("sb_status_cs_low", 32'(rd), 32'h09);
    check("sb_oe", 32'(spi_miso_oe), 32'h1);
    spi_end();
    check("sb_miso", 32'(rx), 32'hA5);
    cpu_rd(A_STAT, rd); check("sb_status_after", 32'(rd), 32'h01);
    check("sb_irqb", 32'(irqb), 32'h1);
    check("sb_oe_after", 32'(spi_miso_oe), 32'h0);
    cpu_rd(A_DATA, rd); check("sb_data", 32'(rd), 32'h3C);
    cpu_rd(A_STAT, rd); check("sb_status_read", 32'(rd), 32'h00);

    // Underrun and fill
    cpu_wr(A_FILL, 8'h5A);
    spi_begin();
    spi_xfer(8'h96, 8, 1'b1, rx);
    spi_end();
    check("ur_miso", 32'(rx), 32'h5A);
    cpu_rd(A_STAT, rd); check("ur_status", 32'(rd), 32'h11);
    cpu_rd(A_DATA, rd); check("ur_data", 32'(rd), 32'h96);
    cpu_wr(A_STAT, 8'h10);
    cpu_rd(A_STAT, rd); check("ur_w1c", 32'(rd), 32'h00);

    // Overrun with back-to-back bytes
    spi_begin();
    spi_xfer(8'h11, 8, 1'b0, rx);
    spi_xfer(8'h22, 8, 1'b1, rx2);
    spi_end();
    check("ov_miso0", 32'(rx), 32'h5A);
    check("ov_miso1", 32'(rx2), 32'h5A);
    cpu_rd(A_STAT, rd); check("ov_status", 32'(rd), 32'h15);
    cpu_rd(A_DATA, rd); check("ov_data", 32'(rd), 32'h11);
    cpu_rd(A_STAT, rd); check("ov_status_read", 32'(rd), 32'h14);
    cpu_wr(A_STAT, 8'h14);
    cpu_rd(A_STAT, rd); check("ov_w1c", 32'(rd), 32'h00);

    // Interrupt timing
    cpu_wr(A_CTRL, 8'h03);
    cpu_rd(A_CTRL, rd); check("irq_ctrl", 32'(rd), 32'h03);
    spi_begin();
    spi_xfer(8'h7E, 7, 1'b0, rx);
    spi_mosi = 1'b0;
    tick(HALF);
    rx = {rx[6:0], spi_miso};
    spi_clk = 1'b1;
    tick(2);
    check("irq_edge2", 32'(irqb), 32'h1);
    tick(1);
    check("irq_edge3", 32'(irqb), 32'h0);
    tick(HALF - 3);
    spi_end();
    check("irq_miso", 32'(rx), 32'h5A);
    check("irq_held", 32'(irqb), 32'h0);
    cpu_rd(A_DATA, rd); check("irq_data", 32'(rd), 32'h7E);
    check("irq_release", 32'(irqb), 32'h1);
    cpu_wr(A_STAT, 8'h10);

    // Abort after five bits, then a full byte
    spi_begin();
    spi_xfer(8'hF0, 5, 1'b0, rx);
    spi_end();
    cpu_rd(A_STAT, rd); check("ab_status", 32'(rd), 32'h10);
    spi_begin();
    spi_xfer(8'hC3, 8, 1'b1, rx);
    spi_end();
    cpu_rd(A_STAT, rd); check("ab_status_next", 32'(rd), 32'h11);
    cpu_rd(A_DATA, rd); check("ab_data_next", 32'(rd), 32'hC3);
    cpu_wr(A_STAT, 8'h10);

    // Reset mid-frame
    cpu_wr(A_DATA, 8'h81);
    spi_begin();
    spi_xfer(8'hAA, 4, 1'b0, rx);
    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    tick(3);
    check("mr_irqb", 32'(irqb), 32'h1);
    check("mr_oe", 32'(spi_miso_oe), 32'h0);
    check("mr_miso", 32'(spi_miso), 32'h0);
    rst = 1'b0;
    tick(1);
    cpu_rd(A_STAT, rd); check("mr_status", 32'(rd), 32'h00);
    cpu_rd(A_CTRL, rd); check("mr_ctrl", 32'(rd), 32'h00);
    cpu_rd(A_FILL, rd); check("mr_fill", 32'(rd), 32'hFF);
    cpu_rd(A_DATA, rd); check("mr_data", 32'(rd), 32'h00);

    // DATA write in the same cycle as the frame-start reload
    cpu_wr(A_CTRL, 8'h01);
    cpu_wr(A_FILL, 8'hC6);
    spi_cs_n = 1'b0;
    tick(2);
    check("co_miso_pre", 32'(spi_miso), 32'h0);
    cpu_wr(A_DATA, 8'h3D);
    check("co_miso_first", 32'(spi_miso), 32'h1);
    cpu_rd(A_STAT, rd); check("co_status", 32'(rd), 32'h1A);
    tick(5);
    spi_xfer(8'h00, 8, 1'b1, rx);
    spi_end();
    check("co_miso", 32'(rx), 32'hC6);
    cpu_rd(A_STAT, rd); check("co_status_after", 32'(rd), 32'h13);
    cpu_rd(A_DATA, rd); check("co_data", 32'(rd), 32'h00);
    spi_begin();
    spi_xfer(8'hFF, 8, 1'b1, rx);
    spi_end();
    check("co_miso_next", 32'(rx), 32'h3D);
    cpu_rd(A_STAT, rd); check("co_status_next", 32'(rd), 32'h11);
    cpu_rd(A_DATA, rd); check("co_data_next", 32'(rd), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI-mode-0 responder with a CPU register interface, the far end of the `spi_controller` protocol. It lets a second board, or a bench model, act as the SPI initiator toward the super6502 bus. It sits on `clk_cpu` alongside the other memory-mapped peripherals and presents one RX byte, one TX byte and one active-low interrupt. The SPI pins are asynchronous and are oversampled by `i_clk`.

## Interface
- `FILL_DEFAULT`, default 8'hFF: reset value of the fill register.
- `i_clk` in 1: CPU clock; the only clock.
- `i_rst` in 1: reset, synchronous to `i_clk` and active-high.
- `i_cs` in 1: register select, decoded by the top level.
- `i_rwb` in 1: 1 = read, 0 = write.
- `i_addr` in 2: register index.
- `i_data` in 8: write data.
- `o_data` out 8: read data, combinational from `i_addr`.
- `o_irqb` out 1: interrupt, active-low.
- `i_spi_cs_n` in 1: initiator chip select, active-low, asynchronous.
- `i_spi_clk` in 1: SCK, asynchronous.
- `i_spi_mosi` in 1: initiator-to-target data.
- `o_spi_miso` out 1: target-to-initiator data.
- `o_spi_miso_oe` out 1: MISO output enable.

## Operation
- Register map by `i_addr`:
  - 0 DATA. Read returns `rx_buf` and clears `rx_full`. Write loads `tx_buf` and sets `tx_full`.
  - 1 STATUS. Bit0 `rx_full`, bit1 `tx_full`, bit2 `overrun`, bit3 `busy` (synced CS asserted), bit4 `underrun`. Writing 1 to bit2 or bit4 clears that bit; all other bits are read-only.
  - 2 CTRL, read/write. Bit0 `en`, bit1 `rx_irq_en`. Remaining bits read 0.
  - 3 FILL, read/write: byte sent when no TX byte is pending.
- Register side effects occur only in a cycle with `i_cs=1`, one per cycle.
- `o_irqb = ~(rx_irq_en & rx_full)`.
- SPI format: mode 0, MSB first. MOSI is sampled on SCK rise; MISO changes on SCK fall.
- Synchronizers: `i_spi_cs_n`, `i_spi_clk` and `i_spi_mosi` each pass through 2 flops. SCK and CS get one further stage for edge detection.
- Frame state machine, states IDLE / SHIFT:
  - IDLE → SHIFT on the synced CS falling edge with `en=1`.
    - Shifter loads `tx_buf` if `tx_full` is set, clearing `tx_full`.
    - Otherwise the shifter loads FILL and `underrun` is set.
    - `bit_cnt` is set to 0.
  - SHIFT, on SCK rise: shift in MOSI, `bit_cnt++`.
    - On reaching 8, `rx_buf` takes the assembled byte and `rx_full` is set.
    - If `rx_full` was already 1, `rx_buf` is left unchanged and `overrun` is set.
  - SHIFT, on SCK fall:
    - If `bit_cnt` is 8, reload the shifter from TX/FILL using the same rule as frame start and set `bit_cnt` to 0. This supports back-to-back bytes.
    - Otherwise shift out the next bit.
  - SHIFT → IDLE on the synced CS rising edge. A partial byte is discarded, with no `rx_full` and no `overrun`.
- `o_spi_miso` = shifter MSB. `o_spi_miso_oe = en & busy`.
- `en=0`: forces IDLE and ignores SPI edges. Register access still works.
- Simultaneous events:
  - A CPU DATA write in the same cycle as a shifter load is not consumed by that load. `tx_full` is 1 afterwards.
  - A CPU DATA read in the same cycle as byte completion returns the old `rx_buf`. The new byte is stored, `rx_full` stays 1, and no overrun is flagged.
  - A W1C in the same cycle as a new set of that flag: set wins.
- Reset values:
  - `rx_buf`, `tx_buf`, CTRL and all flags are 0.
  - FILL = `FILL_DEFAULT`.
  - State is IDLE.
  - `o_irqb`=1, `o_spi_miso_oe`=0, `o_spi_miso`=0.
- Reset mid-frame aborts the frame. The block stays in IDLE until a fresh CS falling edge arrives after `en` is set.

## Timing
- SCK high and low times must each be ≥3 `i_clk` periods. CS setup before the first SCK rise must be ≥4 `i_clk` periods.
- SCK edge on the pin to internal action: 3 `i_clk` edges. `rx_full`/`o_irqb` update on the 3rd edge after the 8th SCK rise.
- MISO update lags SCK fall by 3 `i_clk` periods; this must fall within the SCK low time.
- The first MISO bit is valid 3 `i_clk` periods after CS falls.
- `o_data` is combinational. STATUS/DATA read effects take place at the end of the access cycle.

## Structure
- Package `spi_target_pkg` holds:
  - the register address enum (`REG_DATA`, `REG_STATUS`, `REG_CTRL`, `REG_FILL`);
  - STATUS and CTRL bit-index constants;
  - the state enum.
- Sub-module `sync_edge`: 2-flop synchronizer plus registered edge detect, with outputs `level`, `rise`, `fall`. It is instantiated for SCK and CS; MOSI uses the synchronizer path only.

## Test plan
- **Single byte:** `en=1`, write DATA=8'hA5, initiator sends 8'h3C with SCK=8 `i_clk`/half-period. Required: MISO carries A5; `rx_buf`=3C; STATUS=8'h09 while CS is low, then 8'h01; `o_irqb` stays 1.
- **Underrun and fill:** FILL=8'h5A, no DATA write, one byte. Required: MISO carries 5A; STATUS bit4 set; W1C 8'h10 clears it.
- **Overrun:** two back-to-back bytes 11, 22 with no CPU read between them. Required: `rx_buf`=11; `overrun`=1; read DATA returns 11 and clears `rx_full`.
- **Interrupt:** `rx_irq_en=1`, receive 8'h7E. Required: `o_irqb` goes 0 on the 3rd `i_clk` edge after the 8th SCK rise, and returns to 1 the cycle after the DATA read.
- **Abort:** CS rises after 5 bits. Required: no `rx_full`; `busy`=0; the next full byte is received correctly. Assert `i_rst` mid-frame: all outputs return to reset values.
- **Collision:** CPU DATA write in the exact cycle the shifter reloads. Required: the current byte is FILL, and `tx_full`=1 afterwards.
